mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral that answers the single-cycle CPU's data-bus accesses. It sits beside the data memory and uses the same bus: write strobe, byte address, access type, write data and read data. It provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and an interrupt line. Reads are combinational so that loads complete in the same cycle. Writes and counting take effect on the rising clock edge.

## Interface
- BASE, 32'hFFFF_0000: base address. The block is hit when addr[31:4] == BASE[31:4].
- PRESCALE, 4: clk cycles per count tick, ≥1. The prescaler is PRESCALE-wide enough, at most 16 bits.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_w  in  1  write strobe from the CPU.
- addr  in  32  byte address from the CPU.
- dmType  in  3  access type:
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - others treated as word
- din  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dout  out  32  load data, extended per dmType; 0 when not hit.
- hit  out  1  combinational; addr falls in this block's window. Used by the top level to mux dout against the data memory.
- irq  out  1  registered; equals STATUS.pend & CTRL.ie.

## Operation
- Register map (offset = addr[3:2]):
  - 0 CTRL: bit0 en, bit1 autoreload, bit2 ie; other bits read 0.
  - 1 COUNT: 32-bit, read/write.
  - 2 COMPARE: 32-bit, read/write.
  - 3 STATUS: bit0 pend. Writing 1 to bit0 clears pend; writing 0 has no effect.
- Lane handling (lane = addr[1:0]):
  - Word access requires lane==0.
  - Half access requires lane[0]==0 and uses bits [16*lane[1] +: 16].
  - Byte access uses bits [8*lane +: 8].
- Sub-word writes merge into the addressed lanes only; the other bytes are preserved.
- Sub-word reads extract the addressed lane, then sign- or zero-extend it per dmType.
- Misaligned access (word with lane≠0, half with lane[0]=1): the write is ignored and dout=0. This is not an error.
- An access with hit=0 has dout=0 and changes no state, even if mem_w=1.
- Prescaler:
  - pre counts 0..PRESCALE-1 while en=1, and is held at 0 while en=0.
  - tick is asserted in the cycle where pre==PRESCALE-1 and en=1.
- On a tick, the next state is:
  - If COUNT==COMPARE: pend←1, and COUNT←(autoreload ? 0 : COUNT+1).
  - Otherwise COUNT←COUNT+1.
  - Addition is modulo 2^32, so 0xFFFF_FFFF wraps to 0. A wrap does not set pend unless COMPARE matches.
- Priority when events coincide in the same cycle:
  - A CPU write to COUNT beats a tick: the written value is loaded and the tick increment is discarded, though the match check still uses the pre-write COUNT.
  - A match that sets pend beats a W1C clear of pend in the same cycle: pend stays 1.
  - Writing CTRL.en=0 clears pre in the same edge. A tick occurring in that same cycle still applies.
- Reset: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, pend=0, pre=0, irq=0.
- Reset beats every write or tick in the same cycle.
- Asserting reset mid-count discards all state.

## Timing
- Read latency is 0 cycles: dout is combinational from addr, dmType and the registers. Reads have no side effects; reading STATUS does not clear pend.
- A write sampled at edge N is visible on dout after edge N.
- The first tick occurs PRESCALE cycles after the edge that sets en=1.
- pend is set at the edge of the matching tick.
- irq rises one edge after pend, because irq is registered from pend&ie.
- A W1C write to STATUS at edge N drops pend at N, and drops irq at N+1.
- There is no handshake: the CPU completes every access in one cycle.

## Test plan
- Reset defaults: assert reset for 2 cycles, then read all four offsets with dmType=000.
  - Required: 0, 0, 0xFFFF_FFFF, 0; irq=0.
- Count and match: PRESCALE=4. Write COMPARE=3, then CTRL=0x5 (en, ie).
  - Required: COUNT reads 1 after 4 cycles. pend=1 at the tick where COUNT==3, and COUNT then becomes 4. irq=1 one cycle later.
  - Then write STATUS=1. Required: pend=0 and, one cycle later, irq=0.
- Autoreload: COMPARE=2, CTRL=0x3.
  - Required: COUNT sequence 0,1,2,0,1,2… at each tick, with pend set at the first 2→0 transition.
- Sub-word access:
  - Store word 0x8000_7F80 to COMPARE, then store byte 0x11 at COMPARE+2.
  - Required: word read gives 0x8011_7F80. Byte-signed read at +0 gives 0xFFFF_FF80. Byte-unsigned read at +0 gives 0x80. Half-signed read at +2 gives 0xFFFF_8011.
- Collisions:
  - Write COUNT=0x100 on a tick cycle. Required: the next COUNT read is 0x100.
  - Write STATUS=1 on the same cycle that a match occurs. Required: pend stays 1.
  - Write COUNT=0xFFFF_FFFF with COMPARE=5. Required: the next tick gives 0 and pend=0.
- Decode and misalignment:
  - Word store to BASE+0x10 with hit=0. Required: no register changes and dout=0.
  - Word store to BASE+0x5. Required: ignored.
  - Assert reset mid-count. Required: all registers return to their reset values on the following edge.

Source files
------------

// File: rtl/mmio_timer_if.sv
// Data-bus bundle shared by the CPU and the timer peripheral.
// Same strobe/address/type/data signals the data memory sees, plus hit for the read mux.
interface mmio_timer_if;
    logic        mem_w;
    logic [31:0] addr;
    logic [2:0]  dmType;
    logic [31:0] din;
    logic [31:0] dout;
    logic        hit;

    modport master (
        output mem_w,
        output addr,
        output dmType,
        output din,
        input  dout,
        input  hit
    );

    modport slave (
        input  mem_w,
        input  addr,
        input  dmType,
        input  din,
        output dout,
        output hit
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer: CTRL/COUNT/COMPARE/STATUS registers,
// sticky compare-match flag and a registered interrupt line.
module mmio_timer #(
    parameter logic [31:0] BASE     = 32'hFFFF_0000,
    parameter int          PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ACC_WORD,
        ACC_HALF,
        ACC_BYTE
    } acc_e;

    // ctrl_q: bit0 en, bit1 autoreload, bit2 ie
    logic [2:0]    ctrl_q,    ctrl_d;
    logic [31:0]   count_q,   count_d;
    logic [31:0]   compare_q, compare_d;
    logic          pend_q,    pend_d;
    logic [PW-1:0] pre_q,     pre_d;
    logic          irq_q,     irq_d;

    acc_e        acc;
    logic        sign_ext;
    logic [1:0]  lane;
    logic [1:0]  off;
    logic        hit;
    logic        aligned;
    logic        valid;
    logic [3:0]  be;
    logic [31:0] wmask;
    logic [31:0] wdata_al;
    logic [31:0] rd_reg;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    logic        wr_ok;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        tick;
    logic        match;
    logic        pend_clr;

    assign lane = bus.addr[1:0];
    assign off  = bus.addr[3:2];
    assign hit  = (bus.addr[31:4] == BASE[31:4]);

    always_comb begin
        acc      = ACC_WORD;
        sign_ext = 1'b0;
        case (bus.dmType)
            3'b001:  begin acc = ACC_HALF; sign_ext = 1'b1; end
            3'b010:  begin acc = ACC_HALF; sign_ext = 1'b0; end
            3'b011:  begin acc = ACC_BYTE; sign_ext = 1'b1; end
            3'b100:  begin acc = ACC_BYTE; sign_ext = 1'b0; end
            default: begin acc = ACC_WORD; sign_ext = 1'b0; end
        endcase
    end

    always_comb begin
        aligned  = 1'b1;
        be       = 4'b0000;
        wdata_al = bus.din;
        case (acc)
            ACC_HALF: begin
                aligned  = ~lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{bus.din[15:0]}};
            end
            ACC_BYTE: begin
                aligned  = 1'b1;
                be       = 4'b0001 << lane;
                wdata_al = {4{bus.din[7:0]}};
            end
            default: begin
                aligned  = (lane == 2'b00);
                be       = 4'b1111;
                wdata_al = bus.din;
            end
        endcase
    end

    assign valid = hit & aligned;
    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    always_comb begin
        rd_reg = 32'd0;
        case (off)
            OFF_CTRL:    rd_reg = {29'd0, ctrl_q};
            OFF_COUNT:   rd_reg = count_q;
            OFF_COMPARE: rd_reg = compare_q;
            OFF_STATUS:  rd_reg = {31'd0, pend_q};
            default:     rd_reg = 32'd0;
        endcase
    end

    assign rd_byte = rd_reg[{lane, 3'b000} +: 8];
    assign rd_half = rd_reg[{lane[1], 4'b0000} +: 16];

    always_comb begin
        rd_ext = rd_reg;
        case (acc)
            ACC_HALF: rd_ext = {{16{sign_ext & rd_half[15]}}, rd_half};
            ACC_BYTE: rd_ext = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            default:  rd_ext = rd_reg;
        endcase
    end

    assign bus.hit  = hit;
    assign bus.dout = valid ? rd_ext : 32'd0;

    assign wr_ok      = bus.mem_w & valid;
    assign wr_ctrl    = wr_ok & (off == OFF_CTRL);
    assign wr_count   = wr_ok & (off == OFF_COUNT);
    assign wr_compare = wr_ok & (off == OFF_COMPARE);
    assign wr_status  = wr_ok & (off == OFF_STATUS);

    assign tick     = ctrl_q[0] & (pre_q == PRE_LAST);
    assign match    = (count_q == compare_q);
    // W1C looks only at the written lane data, never at merged old contents
    assign pend_clr = wr_status & be[0] & wdata_al[0];

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        pend_d    = pend_q;
        pre_d     = pre_q;
        irq_d     = pend_q & ctrl_q[2];

        if (wr_ctrl) begin
            ctrl_d = (ctrl_q & ~wmask[2:0]) | (wdata_al[2:0] & wmask[2:0]);
        end

        if (pend_clr) begin
            pend_d = 1'b0;
        end

        if (tick) begin
            if (match) begin
                pend_d  = 1'b1;
                count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // CPU write overrides the tick result; match above used the old COUNT
        if (wr_count) begin
            count_d = (count_q & ~wmask) | (wdata_al & wmask);
        end

        if (wr_compare) begin
            compare_d = (compare_q & ~wmask) | (wdata_al & wmask);
        end

        if (!ctrl_q[0] || !ctrl_d[0]) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= 3'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            pend_q    <= 1'b0;
            pre_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
            pre_q     <= pre_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register defaults, counting/match/irq, autoreload,
// sub-word access, same-cycle collisions, decode/misalignment and mid-count reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam int          PRESCALE = 4;

    localparam logic [31:0] A_CTRL  = BASE + 32'h0;
    localparam logic [31:0] A_COUNT = BASE + 32'h4;
    localparam logic [31:0] A_CMP   = BASE + 32'h8;
    localparam logic [31:0] A_STAT  = BASE + 32'hC;

    localparam logic [2:0] T_W  = 3'b000;
    localparam logic [2:0] T_HS = 3'b001;
    localparam logic [2:0] T_HU = 3'b010;
    localparam logic [2:0] T_BS = 3'b011;
    localparam logic [2:0] T_BU = 3'b100;

    logic clk;
    logic reset;
    logic irq;
    int   n_assert;
    int   n_fail;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE     (BASE),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp);
        bus.mem_w  = 1'b0;
        bus.addr   = a;
        bus.dmType = t;
        #1;
        chk(tag, bus.dout, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
        bus.mem_w  = 1'b1;
        bus.addr   = a;
        bus.dmType = t;
        bus.din    = d;
        @(posedge clk);
        #1;
        bus.mem_w  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.mem_w  = 1'b0;
        bus.addr   = 32'd0;
        bus.dmType = T_W;
        bus.din    = 32'd0;

        // reset defaults
        step(2);
        reset = 1'b0;
        rd_chk("rst_ctrl",    A_CTRL,  T_W, 32'h0);
        rd_chk("rst_count",   A_COUNT, T_W, 32'h0);
        rd_chk("rst_compare", A_CMP,   T_W, 32'hFFFF_FFFF);
        rd_chk("rst_status",  A_STAT,  T_W, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_hit", {31'd0, bus.hit}, 32'd1);

        // count and match, ticks every 4 cycles after enable
        wr(A_CMP, T_W, 32'd3);
        wr(A_CTRL, T_W, 32'h5);
        step(3);
        rd_chk("cnt_pre_tick", A_COUNT, T_W, 32'd0);
        step(1);
        rd_chk("cnt_first_tick", A_COUNT, T_W, 32'd1);
        step(11);
        rd_chk("cnt_at_3", A_COUNT, T_W, 32'd3);
        rd_chk("pend_before_match", A_STAT, T_W, 32'd0);
        step(1);
        rd_chk("cnt_after_match", A_COUNT, T_W, 32'd4);
        rd_chk("pend_on_match", A_STAT, T_W, 32'd1);
        chk("irq_same_edge", {31'd0, irq}, 32'd0);
        step(1);
        chk("irq_one_later", {31'd0, irq}, 32'd1);
        rd_chk("status_read_no_clear", A_STAT, T_W, 32'd1);
        wr(A_STAT, T_W, 32'd1);
        rd_chk("pend_w1c", A_STAT, T_W, 32'd0);
        chk("irq_hold_after_w1c", {31'd0, irq}, 32'd1);
        step(1);
        chk("irq_drop_after_w1c", {31'd0, irq}, 32'd0);

        // autoreload: 0,1,2,0,1
        wr(A_CTRL, T_W, 32'h0);
        wr(A_COUNT, T_W, 32'd0);
        wr(A_CMP, T_W, 32'd2);
        wr(A_CTRL, T_W, 32'h3);
        rd_chk("ar_ctrl", A_CTRL, T_W, 32'h3);
        step(4);
        rd_chk("ar_t1", A_COUNT, T_W, 32'd1);
        rd_chk("ar_t1_pend", A_STAT, T_W, 32'd0);
        step(4);
        rd_chk("ar_t2", A_COUNT, T_W, 32'd2);
        rd_chk("ar_t2_pend", A_STAT, T_W, 32'd0);
        step(4);
        rd_chk("ar_t3_reload", A_COUNT, T_W, 32'd0);
        rd_chk("ar_t3_pend", A_STAT, T_W, 32'd1);
        chk("ar_irq_masked", {31'd0, irq}, 32'd0);
        step(4);
        rd_chk("ar_t4", A_COUNT, T_W, 32'd1);

        // sub-word access on COMPARE
        wr(A_CTRL, T_W, 32'h0);
        wr(A_STAT, T_W, 32'h1);
        wr(A_CMP, T_W, 32'h8000_7F80);
        wr(A_CMP + 32'd2, T_BU, 32'h0000_0011);
        rd_chk("sw_word",   A_CMP,          T_W,  32'h8011_7F80);
        rd_chk("sw_bs0",    A_CMP,          T_BS, 32'hFFFF_FF80);
        rd_chk("sw_bu0",    A_CMP,          T_BU, 32'h0000_0080);
        rd_chk("sw_hs2",    A_CMP + 32'd2,  T_HS, 32'hFFFF_8011);
        rd_chk("sw_hu2",    A_CMP + 32'd2,  T_HU, 32'h0000_8011);
        rd_chk("sw_bu3",    A_CMP + 32'd3,  T_BU, 32'h0000_0080);
        wr(A_CMP, T_HU, 32'hABCD_1234);
        rd_chk("sw_half_merge", A_CMP, T_W, 32'h8011_1234);

        // collision: COUNT write on a tick edge
        wr(A_CMP, T_W, 32'hFFFF_FFF0);
        wr(A_COUNT, T_W, 32'd0);
        wr(A_CTRL, T_W, 32'h1);
        step(3);
        wr(A_COUNT, T_W, 32'h100);
        rd_chk("col_write_beats_tick", A_COUNT, T_W, 32'h100);
        step(3);
        rd_chk("col_hold", A_COUNT, T_W, 32'h100);
        step(1);
        rd_chk("col_next_tick", A_COUNT, T_W, 32'h101);

        // collision: W1C on the matching tick edge
        wr(A_CMP, T_W, 32'h102);
        step(6);
        wr(A_STAT, T_W, 32'h1);
        rd_chk("col_match_beats_w1c", A_STAT, T_W, 32'd1);
        rd_chk("col_match_count", A_COUNT, T_W, 32'h103);
        wr(A_STAT, T_W, 32'h1);
        rd_chk("col_w1c_later", A_STAT, T_W, 32'd0);

        // wrap without match
        wr(A_CMP, T_W, 32'd5);
        wr(A_COUNT, T_W, 32'hFFFF_FFFF);
        rd_chk("wrap_loaded", A_COUNT, T_W, 32'hFFFF_FFFF);
        step(1);
        rd_chk("wrap_count", A_COUNT, T_W, 32'd0);
        rd_chk("wrap_pend", A_STAT, T_W, 32'd0);

        // decode miss and misaligned accesses
        wr(A_CTRL, T_W, 32'h0);
        bus.mem_w  = 1'b1;
        bus.addr   = BASE + 32'h10;
        bus.dmType = T_W;
        bus.din    = 32'h0000_0007;
        #1;
        chk("miss_hit", {31'd0, bus.hit}, 32'd0);
        chk("miss_dout", bus.dout, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_w = 1'b0;
        rd_chk("miss_ctrl", A_CTRL, T_W, 32'h0);
        rd_chk("miss_count", A_COUNT, T_W, 32'd0);

        bus.mem_w  = 1'b1;
        bus.addr   = BASE + 32'h5;
        bus.dmType = T_W;
        bus.din    = 32'h1234_5678;
        #1;
        chk("mis_hit", {31'd0, bus.hit}, 32'd1);
        chk("mis_dout", bus.dout, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_w = 1'b0;
        rd_chk("mis_word_ignored", A_COUNT, T_W, 32'd0);
        wr(BASE + 32'h9, T_HU, 32'h0000_AAAA);
        rd_chk("mis_half_ignored", A_CMP, T_W, 32'd5);

        // reset mid-count with pend and irq set, concurrent write discarded
        wr(A_CMP, T_W, 32'h55);
        wr(A_COUNT, T_W, 32'h55);
        wr(A_CTRL, T_W, 32'h5);
        step(5);
        rd_chk("pre_rst_count", A_COUNT, T_W, 32'h56);
        rd_chk("pre_rst_pend", A_STAT, T_W, 32'd1);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        reset      = 1'b1;
        bus.mem_w  = 1'b1;
        bus.addr   = A_CMP;
        bus.dmType = T_W;
        bus.din    = 32'h1234;
        step(1);
        bus.mem_w = 1'b0;
        rd_chk("mid_rst_ctrl",    A_CTRL,  T_W, 32'h0);
        rd_chk("mid_rst_count",   A_COUNT, T_W, 32'h0);
        rd_chk("mid_rst_compare", A_CMP,   T_W, 32'hFFFF_FFFF);
        rd_chk("mid_rst_status",  A_STAT,  T_W, 32'h0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
